ftl_port_arbiter: RTL and testbench
===================================

Name: ftl_port_arbiter

Overview:
- Round-robin arbiter sharing the single FTL address-translation port (address, valid, rw, new address, resp, cache hit) among NUM_REQ burst controllers.
- Sits between the burst controller instances and the FTL controller.
- Locks the grant for one full four-phase transaction: valid, then resp high, then resp low.
- Forwards the translated address and cache-hit status back to the granted requester only.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ADDR_WIDTH, 32, logical/physical address width.
- ID_W, $clog2(NUM_REQ) (minimum 1), grant index width.
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles; used only with FTL_ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- req_valid_i  in  NUM_REQ  per-requester translation request.
- req_rw_i  in  NUM_REQ  per-requester mode (0 read, 1 write).
- req_addr_i  in  NUM_REQ*ADDR_WIDTH  packed logical addresses; requester k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- req_resp_o  out  NUM_REQ  per-requester response, one-hot or zero.
- req_new_addr_o  out  ADDR_WIDTH  translated address, broadcast to all requesters.
- req_hit_o  out  1  cache hit, broadcast to all requesters.
- ftl_valid_o  out  1  request to FTL.
- ftl_rw_o  out  1  mode to FTL.
- ftl_address_o  out  ADDR_WIDTH  logical address to FTL.
- ftl_new_address_i  in  ADDR_WIDTH  translated address from FTL.
- ftl_resp_i  in  1  FTL response level.
- ftl_hit_i  in  1  FTL cache hit.
- busy_o  out  1  a grant is held.
- grant_id_o  out  ID_W  current or last granted requester.

Behaviour:
- State machine: IDLE, REQ, DRAIN. All flops use synchronous rst_i.
- Reset values: state=IDLE, rr_ptr=0, grant_id_o=0, busy_o=0. In IDLE, ftl_valid_o, ftl_rw_o, ftl_address_o and req_resp_o are all 0.
- IDLE:
  - Search req_valid_i starting at index rr_ptr, ascending with wrap-around.
  - If any bit is set: register the first hit into grant_id_o, then go to REQ on the next edge. Arbitration latency is 1 cycle.
  - ftl_resp_i is ignored in IDLE; a spurious response has no effect.
- REQ:
  - ftl_valid_o=1. ftl_address_o and ftl_rw_o are combinationally muxed from requester grant_id_o. busy_o=1.
  - req_resp_o[grant_id_o]=ftl_resp_i; all other req_resp_o bits are 0.
  - When ftl_resp_i=1, go to DRAIN. A response in the first REQ cycle is legal.
  - Requests are non-retractable. If req_valid_i[grant_id_o] drops before the response, the request stays asserted until ftl_resp_i.
- DRAIN:
  - ftl_valid_o=0, busy_o=1. req_resp_o[grant_id_o]=ftl_resp_i is still forwarded.
  - Stay while ftl_resp_i=1; a response held any number of cycles is legal.
  - On ftl_resp_i=0: go to IDLE and set rr_ptr=(grant_id_o+1) mod NUM_REQ. The mod wraps at NUM_REQ, not 2^ID_W.
- Broadcast outputs: req_new_addr_o=ftl_new_address_i and req_hit_o=ftl_hit_i in every state. Requesters qualify them with their own req_resp_o bit.
- Throughput: minimum 3 cycles per transaction (IDLE, REQ, DRAIN). No back-to-back grant without passing through IDLE.
- Fairness: a continuously requesting port waits at most NUM_REQ-1 transactions.
- Requests arriving during REQ/DRAIN are held by the requester and seen at the next IDLE.
- Reset mid-operation: return to IDLE the next cycle with all outputs at reset values. Any in-flight FTL transaction is abandoned.
- grant_id_o holds its value in IDLE when no request is pending.

Optional Feature:
- Macro FTL_ARB_TIMEOUT_EN.
- Defined:
  - Adds a 16-bit watchdog counter: cleared on entry to REQ, increments in REQ and DRAIN.
  - If it reaches TIMEOUT_CYCLES: force state=IDLE, advance rr_ptr as in normal completion, and drive req_resp_o=0.
  - Sets sticky output timeout_o (1 bit) and captures timeout_id_o (ID_W) = the stalled grant_id. Both clear only on rst_i.
- Not defined: no counter and no timeout_o/timeout_id_o ports. The arbiter waits indefinitely in REQ/DRAIN.

Test Plan:
- Single request: req_valid_i=4'b0100, addr 0x1000, rw=1; FTL answers resp after 3 cycles with new_addr 0xA000, hit=1.
  -> ftl_valid_o=1 from cycle 2 with ftl_address_o=0x1000 and ftl_rw_o=1. req_resp_o=4'b0100 while resp is high. req_new_addr_o=0xA000, req_hit_o=1. After resp drops: busy_o=0 and rr_ptr=3.
- Contention from reset: req_valid_i=4'b1010 held.
  -> Grants in order 1, 3, 1, 3. Never two req_resp_o bits set in the same cycle.
- Full fairness: all four ports requesting continuously.
  -> Grant sequence 0, 1, 2, 3, 0, each transaction separated by one IDLE cycle.
- Responses: FTL holds resp high for 5 cycles -> arbiter remains in DRAIN 5 cycles with ftl_valid_o=0. A resp pulse during IDLE -> no req_resp_o activity.
- Reset mid-operation: assert rst_i during REQ for port 2 -> next cycle all outputs zero and state IDLE. After release with port 2 still requesting, port 0 (rr_ptr=0) is granted if it is also requesting.
- Timeout (FTL_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): FTL never responds to port 1.
  -> After 8 cycles: state IDLE, timeout_o=1, timeout_id_o=1, next grant goes to port 2.

Source files
------------

// File: rtl/ftl_port_arbiter.sv
// Round-robin arbiter sharing one FTL translation port among NUM_REQ burst controllers; grant held for a full valid/resp-high/resp-low handshake.
// Latency: 1 cycle from request to ftl_valid_o; at least 3 cycles per transaction (IDLE, REQ, DRAIN).
// Backpressure: requests are held by the requesters until their own req_resp_o bit rises. Optional watchdog: FTL_ARB_TIMEOUT_EN.
module ftl_port_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int ID_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_rw_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    output logic [NUM_REQ-1:0]            req_resp_o,
    output logic [ADDR_WIDTH-1:0]         req_new_addr_o,
    output logic                          req_hit_o,
    output logic                          ftl_valid_o,
    output logic                          ftl_rw_o,
    output logic [ADDR_WIDTH-1:0]         ftl_address_o,
    input  logic [ADDR_WIDTH-1:0]         ftl_new_address_i,
    input  logic                          ftl_resp_i,
    input  logic                          ftl_hit_i,
`ifdef FTL_ARB_TIMEOUT_EN
    output logic                          timeout_o,
    output logic [ID_W-1:0]               timeout_id_o,
`endif
    output logic                          busy_o,
    output logic [ID_W-1:0]               grant_id_o
);

    if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
        $error("ftl_port_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [ID_W-1:0]        rr_ptr;
    logic [ID_W-1:0]        next_ptr;
    logic                   pick_vld;
    logic [ID_W-1:0]        pick_id;
    int                     off;
    int                     best_off;
    logic [NUM_REQ-1:0]     grant_onehot;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic                   sel_rw;
    logic                   xact_done;
    logic                   wdog_fire;

    assign req_new_addr_o = ftl_new_address_i;
    assign req_hit_o      = ftl_hit_i;

    // Pick the valid requester with the smallest distance ahead of rr_ptr.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        best_off = NUM_REQ;
        off      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_valid_i[k]) begin
                off = (k >= int'(rr_ptr)) ? (k - int'(rr_ptr)) : (k + NUM_REQ - int'(rr_ptr));
                if (off < best_off) begin
                    best_off = off;
                    pick_vld = 1'b1;
                    pick_id  = ID_W'(k);
                end
            end
        end
    end

    always_comb begin
        grant_onehot = '0;
        sel_addr     = '0;
        sel_rw       = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_id_o == ID_W'(k)) begin
                grant_onehot[k] = 1'b1;
                sel_addr        = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                sel_rw          = req_rw_i[k];
            end
        end
    end

    // Wrap explicitly at NUM_REQ so non-power-of-two configurations stay in range.
    assign next_ptr = (grant_id_o == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_o + 1'b1;

`ifdef FTL_ARB_TIMEOUT_EN
    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wdog;

    assign wdog_fire = (state != IDLE) && (wdog == WDOG_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wdog         <= '0;
            timeout_o    <= 1'b0;
            timeout_id_o <= '0;
        end else begin
            wdog <= (state == IDLE) ? 16'd0 : wdog + 16'd1;
            if (wdog_fire) begin
                timeout_o    <= 1'b1;
                timeout_id_o <= grant_id_o;
            end
        end
    end
`else
    assign wdog_fire = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        ftl_valid_o   = 1'b0;
        ftl_rw_o      = 1'b0;
        ftl_address_o = '0;
        req_resp_o    = '0;
        busy_o        = 1'b0;
        xact_done     = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld) state_nxt = REQ;
            end
            REQ: begin
                ftl_valid_o   = 1'b1;
                ftl_rw_o      = sel_rw;
                ftl_address_o = sel_addr;
                busy_o        = 1'b1;
                req_resp_o    = grant_onehot & {NUM_REQ{ftl_resp_i}};
                if (ftl_resp_i) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy_o     = 1'b1;
                req_resp_o = grant_onehot & {NUM_REQ{ftl_resp_i}};
                if (!ftl_resp_i) begin
                    state_nxt = IDLE;
                    xact_done = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A stalled FTL is abandoned and treated as a completed turn.
        if (wdog_fire) begin
            state_nxt  = IDLE;
            xact_done  = 1'b1;
            req_resp_o = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            grant_id_o <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_vld) grant_id_o <= pick_id;
            if (xact_done) rr_ptr <= next_ptr;
        end
    end

endmodule

// File: tb/tb_ftl_port_arbiter.sv
// Directed bench for ftl_port_arbiter: a per-cycle vector table plus multi-cycle handshake sequences.
module tb_ftl_port_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_rw;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_resp;
    logic [AW-1:0]   req_new_addr;
    logic            req_hit;
    logic            ftl_valid;
    logic            ftl_rw;
    logic [AW-1:0]   ftl_address;
    logic [AW-1:0]   ftl_new_addr;
    logic            ftl_resp;
    logic            ftl_hit;
    logic            busy;
    logic [IW-1:0]   grant_id;
`ifdef FTL_ARB_TIMEOUT_EN
    logic            timeout;
    logic [IW-1:0]   timeout_id;
`endif

    always #5 clk = ~clk;

    ftl_port_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_rw_i(req_rw), .req_addr_i(req_addr),
        .req_resp_o(req_resp), .req_new_addr_o(req_new_addr), .req_hit_o(req_hit),
        .ftl_valid_o(ftl_valid), .ftl_rw_o(ftl_rw), .ftl_address_o(ftl_address),
        .ftl_new_address_i(ftl_new_addr), .ftl_resp_i(ftl_resp), .ftl_hit_i(ftl_hit),
`ifdef FTL_ARB_TIMEOUT_EN
        .timeout_o(timeout), .timeout_id_o(timeout_id),
`endif
        .busy_o(busy), .grant_id_o(grant_id)
    );

    typedef struct {
        logic [3:0]  vld;
        logic        resp;
        logic [31:0] na;
        logic        hit;
        logic        fv;
        logic        rw;
        logic [31:0] addr;
        logic [3:0]  rsp;
        logic        busy;
        logic [1:0]  gid;
    } vec_t;

    vec_t tbl [14];
    int   total = 0;
    int   bad   = 0;
    int   exp_cont [4] = '{1, 3, 1, 3};
    int   exp_fair [5] = '{0, 1, 2, 3, 0};
    int   gid;
    int   gap;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        ftl_resp  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Acts as the FTL for one transaction: waits for a grant, answers after
    // 'delay' cycles and holds resp for 'hold' cycles.
    task automatic serve(input int delay, input int hold, output int g, output int n);
        n = 0;
        g = -1;
        while (ftl_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("serve_start", {31'd0, ftl_valid}, 32'd1);
        if (ftl_valid !== 1'b1) return;
        g = int'(grant_id);
        for (int d = 0; d < delay; d++) begin
            #1;
            chk("wait_resp_zero", {28'd0, req_resp}, 32'd0);
            tick();
        end
        ftl_resp     = 1'b1;
        ftl_new_addr = 32'hA000 + g;
        ftl_hit      = 1'b1;
        #1;
        chk("resp_onehot", {28'd0, req_resp}, 32'd1 << g);
        chk("resp_new_addr", req_new_addr, 32'hA000 + g);
        for (int h = 1; h < hold; h++) begin
            tick();
            #1;
            chk("drain_resp", {28'd0, req_resp}, 32'd1 << g);
            chk("drain_valid", {31'd0, ftl_valid}, 32'd0);
            chk("drain_busy", {31'd0, busy}, 32'd1);
        end
        tick();
        ftl_resp = 1'b0;
        #1;
        chk("drop_resp", {28'd0, req_resp}, 32'd0);
        chk("drop_busy", {31'd0, busy}, 32'd1);
        chk("drop_valid", {31'd0, ftl_valid}, 32'd0);
        tick();
        #1;
        chk("back_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        req_valid    = '0;
        req_rw       = 4'b0110;
        req_addr     = {32'h2000, 32'h1000, 32'h0800, 32'h0400};
        ftl_new_addr = '0;
        ftl_resp     = 1'b0;
        ftl_hit      = 1'b0;

        tbl[0]  = '{4'b0100, 1'b0, 32'h1111, 1'b0, 1'b0, 1'b0, 32'h0,    4'b0000, 1'b0, 2'd0};
        tbl[1]  = '{4'b0100, 1'b0, 32'h2222, 1'b1, 1'b1, 1'b1, 32'h1000, 4'b0000, 1'b1, 2'd2};
        tbl[2]  = '{4'b0100, 1'b0, 32'h2222, 1'b1, 1'b1, 1'b1, 32'h1000, 4'b0000, 1'b1, 2'd2};
        tbl[3]  = '{4'b0100, 1'b1, 32'hA000, 1'b1, 1'b1, 1'b1, 32'h1000, 4'b0100, 1'b1, 2'd2};
        tbl[4]  = '{4'b0000, 1'b1, 32'hA000, 1'b1, 1'b0, 1'b0, 32'h0,    4'b0100, 1'b1, 2'd2};
        tbl[5]  = '{4'b0000, 1'b0, 32'hA000, 1'b1, 1'b0, 1'b0, 32'h0,    4'b0000, 1'b1, 2'd2};
        tbl[6]  = '{4'b0000, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    4'b0000, 1'b0, 2'd2};
        tbl[7]  = '{4'b1111, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    4'b0000, 1'b0, 2'd2};
        tbl[8]  = '{4'b1111, 1'b1, 32'hB000, 1'b0, 1'b1, 1'b0, 32'h2000, 4'b1000, 1'b1, 2'd3};
        tbl[9]  = '{4'b0000, 1'b0, 32'hB000, 1'b0, 1'b0, 1'b0, 32'h0,    4'b0000, 1'b1, 2'd3};
        tbl[10] = '{4'b0000, 1'b1, 32'hC000, 1'b1, 1'b0, 1'b0, 32'h0,    4'b0000, 1'b0, 2'd3};
        tbl[11] = '{4'b0000, 1'b0, 32'hC000, 1'b1, 1'b0, 1'b0, 32'h0,    4'b0000, 1'b0, 2'd3};
        tbl[12] = '{4'b0001, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 32'h0,    4'b0000, 1'b0, 2'd3};
        tbl[13] = '{4'b0001, 1'b0, 32'h0,    1'b0, 1'b1, 1'b0, 32'h0400, 4'b0000, 1'b1, 2'd0};

        tick();
        tick();
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_gid", {30'd0, grant_id}, 32'd0);
        chk("reset_fv", {31'd0, ftl_valid}, 32'd0);
        chk("reset_addr", ftl_address, 32'd0);
        chk("reset_resp", {28'd0, req_resp}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            req_valid    = tbl[i].vld;
            ftl_resp     = tbl[i].resp;
            ftl_new_addr = tbl[i].na;
            ftl_hit      = tbl[i].hit;
            #1;
            chk($sformatf("row%0d_fv", i), {31'd0, ftl_valid}, {31'd0, tbl[i].fv});
            chk($sformatf("row%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].busy});
            chk($sformatf("row%0d_gid", i), {30'd0, grant_id}, {30'd0, tbl[i].gid});
            chk($sformatf("row%0d_resp", i), {28'd0, req_resp}, {28'd0, tbl[i].rsp});
            chk($sformatf("row%0d_new_addr", i), req_new_addr, tbl[i].na);
            chk($sformatf("row%0d_hit", i), {31'd0, req_hit}, {31'd0, tbl[i].hit});
            if (tbl[i].fv || !tbl[i].busy) begin
                chk($sformatf("row%0d_addr", i), ftl_address, tbl[i].addr);
                chk($sformatf("row%0d_rw", i), {31'd0, ftl_rw}, {31'd0, tbl[i].rw});
            end
            tick();
        end

        do_reset();
        req_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            serve(i, 1 + (i % 2), gid, gap);
            chk($sformatf("contention_gid%0d", i), gid, exp_cont[i]);
        end

        // Third transaction holds resp for 5 cycles.
        do_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            serve(i % 2, (i == 2) ? 5 : 1, gid, gap);
            chk($sformatf("fair_gid%0d", i), gid, exp_fair[i]);
            chk($sformatf("fair_gap%0d", i), gap, 1);
        end

        do_reset();
        req_valid = 4'b0100;
        tick();
        #1;
        chk("midrst_pre_gid", {30'd0, grant_id}, 32'd2);
        chk("midrst_pre_fv", {31'd0, ftl_valid}, 32'd1);
        rst       = 1'b1;
        req_valid = 4'b0101;
        ftl_resp  = 1'b1;
        tick();
        #1;
        chk("midrst_fv", {31'd0, ftl_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_gid", {30'd0, grant_id}, 32'd0);
        chk("midrst_resp", {28'd0, req_resp}, 32'd0);
        chk("midrst_addr", ftl_address, 32'd0);
        rst      = 1'b0;
        ftl_resp = 1'b0;
        tick();
        #1;
        chk("midrst_regrant_gid", {30'd0, grant_id}, 32'd0);
        chk("midrst_regrant_addr", ftl_address, 32'h0400);

`ifdef FTL_ARB_TIMEOUT_EN
        do_reset();
        req_valid = 4'b0010;
        tick();
        #1;
        chk("to_gid", {30'd0, grant_id}, 32'd1);
        chk("to_clear", {31'd0, timeout}, 32'd0);
        repeat (7) tick();
        #1;
        chk("to_still_req", {31'd0, ftl_valid}, 32'd1);
        chk("to_not_yet", {31'd0, timeout}, 32'd0);
        req_valid = 4'b0110;
        tick();
        #1;
        chk("to_idle", {31'd0, busy}, 32'd0);
        chk("to_flag", {31'd0, timeout}, 32'd1);
        chk("to_id", {30'd0, timeout_id}, 32'd1);
        tick();
        #1;
        chk("to_next_gid", {30'd0, grant_id}, 32'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
